// File: rtl/enemy_wave_array_if.sv
// Pixel, collision and status bundle between the enemy wave array and the
// game logic / VGA path.
interface enemy_wave_array_if #(
   parameter int N_ENEMIES = 4
);
   logic                 pix_en;
   logic                 pause;
   logic                 game_start_on;
   logic                 game_over_on;
   logic                 p_on;
   logic                 hit_w_enemy;
   logic [9:0]           x;
   logic [9:0]           y;
   logic [23:0]          wave_speed;
   logic [7:0]           color_in;
   logic [3:0]           sprite_row;
   logic [3:0]           sprite_col;
   logic [N_ENEMIES-1:0] is_active;
   logic                 e_w_on;
   logic [7:0]           rgb;
   logic                 kill_pulse;
   logic                 escape_pulse;
   logic [2:0]           kill_idx;

   modport master (
      output pix_en, pause, game_start_on, game_over_on, p_on, hit_w_enemy,
             x, y, wave_speed, color_in,
      input  sprite_row, sprite_col, is_active, e_w_on, rgb,
             kill_pulse, escape_pulse, kill_idx
   );

   modport slave (
      input  pix_en, pause, game_start_on, game_over_on, p_on, hit_w_enemy,
             x, y, wave_speed, color_in,
      output sprite_row, sprite_col, is_active, e_w_on, rgb,
             kill_pulse, escape_pulse, kill_idx
   );
endinterface

// File: rtl/enemy_wave_array.sv
// Array of falling (optionally zig-zagging) wave enemies: timed spawning,
// per-pixel sprite lookup, collision kills and bottom-edge escapes.
module enemy_wave_array #(
   parameter int          N_ENEMIES   = 4,
   parameter int          X0          = 160,
   parameter int          X_STEP      = 128,
   parameter int          BOUND_LEFT  = 144,
   parameter int          BOUND_RIGHT = 784,
   parameter int          BOUND_UP    = 31,
   parameter int          BOUND_DOWN  = 511,
   parameter int          SPAWN_GAP   = 32,
   parameter int          ZIGZAG      = 0,
   parameter logic [7:0]  KEY_COLOR   = 8'hBB
) (
   input logic              clk,
   input logic              rst,
   enemy_wave_array_if.slave bus
);
   localparam logic [9:0]           LEFT_LIM   = 10'(BOUND_LEFT);
   localparam logic [9:0]           RIGHT_LIM  = 10'(BOUND_RIGHT - 16);
   localparam logic [9:0]           TOP        = 10'(BOUND_UP);
   localparam logic [9:0]           BOTTOM_LIM = 10'(BOUND_DOWN - 16);
   localparam logic [15:0]          GAP        = 16'(SPAWN_GAP);
   localparam logic [N_ENEMIES-1:0] ALL_ON     = '1;

   function automatic logic [9:0] spawn_x(input int i);
      return 10'(X0 + i * X_STEP);
   endfunction

   // Reject configurations whose spawn columns would leave the playfield.
   if (N_ENEMIES < 1 || N_ENEMIES > 8) begin : g_bad_count
      $error("enemy_wave_array: N_ENEMIES must be 1..8");
   end
   for (genvar g = 0; g < N_ENEMIES; g++) begin : g_spawn_chk
      if (X0 + g * X_STEP >= BOUND_RIGHT - 16) begin : g_bad_x
         $error("enemy_wave_array: spawn x of enemy %0d is beyond the right bound", g);
      end
   end

   logic [23:0]          speed_clk, speed_clk_n;
   logic [15:0]          spawn_cnt, spawn_cnt_n;
   logic [N_ENEMIES-1:0] active, active_n;
   logic [N_ENEMIES-1:0] dir, dir_n;            // 1 = moving +x
   logic [9:0]           ex [N_ENEMIES];
   logic [9:0]           ey [N_ENEMIES];
   logic [9:0]           ex_n [N_ENEMIES];
   logic [9:0]           ey_n [N_ENEMIES];
   logic                 kill_pulse_q, kill_pulse_n;
   logic                 escape_pulse_q, escape_pulse_n;
   logic [2:0]           kill_idx_q, kill_idx_n;

   logic                 sel_found, sel_act;
   logic [2:0]           sel_idx;
   logic [3:0]           sel_row, sel_col;
   logic                 e_w_on, kill_now;

   // Pick the lowest-index enemy whose 16x16 box covers the current pixel.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned and no latch is inferred.
      sel_found = 1'b0;
      sel_act   = 1'b0;
      sel_idx   = 3'd0;
      sel_row   = 4'd0;
      sel_col   = 4'd0;
      // Walk downwards so the lowest covering index is the one left standing.
      for (int i = N_ENEMIES - 1; i >= 0; i--) begin
         if (bus.x >= ex[i] && bus.x < ex[i] + 10'd16 &&
             bus.y >= ey[i] && bus.y < ey[i] + 10'd16) begin
            sel_found = 1'b1;
            sel_act   = active[i];
            sel_idx   = 3'(i);
            sel_row   = 4'(bus.y - ey[i]);
            sel_col   = 4'(bus.x - ex[i]);
         end
      end
   end

   assign e_w_on   = sel_found && sel_act && (bus.color_in != KEY_COLOR);
   assign kill_now = bus.pix_en && e_w_on && (bus.p_on || bus.hit_w_enemy);

   // Next-state for timing, spawning, motion, kills and game-over clearing.
   always_comb begin
      logic                 step;
      logic                 spawn_now;
      logic [N_ENEMIES-1:0] spawn_mask;
      logic [N_ENEMIES-1:0] esc;

      step        = (speed_clk == 24'd0) && !bus.pause;
      spawn_now   = 1'b0;
      // Lowest clear bit of the mask as it stood before this cycle.
      spawn_mask  = ~active & (active + (N_ENEMIES)'(1));
      esc         = '0;
      active_n    = active;
      dir_n       = dir;
      spawn_cnt_n = spawn_cnt;
      speed_clk_n = speed_clk;

      if (!bus.pause)
         speed_clk_n = (speed_clk >= bus.wave_speed) ? 24'd0 : speed_clk + 24'd1;

      if (step && !bus.game_start_on && !bus.game_over_on && active != ALL_ON) begin
         if (spawn_cnt + 16'd1 == GAP) begin
            spawn_cnt_n = 16'd0;
            spawn_now   = 1'b1;
         end else begin
            spawn_cnt_n = spawn_cnt + 16'd1;
         end
      end

      for (int i = 0; i < N_ENEMIES; i++) begin
         ex_n[i] = ex[i];
         ey_n[i] = ey[i];
         if (step && active[i]) begin
            ey_n[i] = ey[i] + 10'd1;
            if (ey_n[i] >= BOTTOM_LIM) begin
               active_n[i] = 1'b0;
               esc[i]      = 1'b1;
            end
            if (ZIGZAG != 0) begin
               if (dir[i]) begin
                  if (ex[i] + 10'd1 >= RIGHT_LIM) begin
                     ex_n[i]  = RIGHT_LIM;
                     dir_n[i] = 1'b0;
                  end else begin
                     ex_n[i] = ex[i] + 10'd1;
                  end
               end else begin
                  if (ex[i] - 10'd1 <= LEFT_LIM) begin
                     ex_n[i]  = LEFT_LIM;
                     dir_n[i] = 1'b1;
                  end else begin
                     ex_n[i] = ex[i] - 10'd1;
                  end
               end
            end
         end
         if (spawn_now && spawn_mask[i]) begin
            active_n[i] = 1'b1;
            ex_n[i]     = spawn_x(i);
            ey_n[i]     = TOP;
            dir_n[i]    = 1'b1;
         end
         // A kill wins over an escape of the same enemy.
         if (kill_now && sel_idx == 3'(i)) begin
            active_n[i] = 1'b0;
            esc[i]      = 1'b0;
         end
      end

      kill_pulse_n   = kill_now;
      kill_idx_n     = kill_now ? sel_idx : kill_idx_q;
      escape_pulse_n = |esc;

      if (bus.game_over_on) begin
         active_n       = '0;
         kill_pulse_n   = 1'b0;
         kill_idx_n     = kill_idx_q;
         escape_pulse_n = 1'b0;
      end
   end

   // State register with synchronous active-low reset taking priority.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the values from before this edge.
      if (!rst) begin
         speed_clk      <= 24'd0;
         spawn_cnt      <= 16'd0;
         active         <= '0;
         dir            <= '1;
         kill_pulse_q   <= 1'b0;
         escape_pulse_q <= 1'b0;
         kill_idx_q     <= 3'd0;
         // NOTE: the per-enemy position arrays are small flop banks, not a
         // RAM, so resetting them costs nothing special and is required.
         for (int i = 0; i < N_ENEMIES; i++) begin
            ex[i] <= spawn_x(i);
            ey[i] <= TOP;
         end
      end else begin
         speed_clk      <= speed_clk_n;
         spawn_cnt      <= spawn_cnt_n;
         active         <= active_n;
         dir            <= dir_n;
         kill_pulse_q   <= kill_pulse_n;
         escape_pulse_q <= escape_pulse_n;
         kill_idx_q     <= kill_idx_n;
         for (int i = 0; i < N_ENEMIES; i++) begin
            ex[i] <= ex_n[i];
            ey[i] <= ey_n[i];
         end
      end
   end

   assign bus.sprite_row   = sel_row;
   assign bus.sprite_col   = sel_col;
   assign bus.is_active    = active;
   assign bus.e_w_on       = e_w_on;
   assign bus.rgb          = bus.color_in;
   assign bus.kill_pulse   = kill_pulse_q;
   assign bus.escape_pulse = escape_pulse_q;
   assign bus.kill_idx     = kill_idx_q;
endmodule

// File: doc/enemy_wave_array.md
ENEMY_WAVE_ARRAY -- requirements
Module: enemy_wave_array

Interface
REQ-001 Parameter N_ENEMIES, default 4: number of wave enemies in the array (1..8).
REQ-002 Parameter X0, default 160: spawn x of enemy 0.
REQ-003 Parameter X_STEP, default 128: spawn x spacing; enemy i spawns at X0 + i*X_STEP.
REQ-004 Parameter BOUND_LEFT/BOUND_RIGHT/BOUND_UP/BOUND_DOWN, defaults 144/784/31/511: display bounds.
REQ-005 Parameter SPAWN_GAP, default 32: speed ticks between successive spawns.
REQ-006 Parameter ZIGZAG, default 0: 0 = vertical fall only, 1 = vertical fall plus horizontal bounce.
REQ-007 Parameter KEY_COLOR, default 8'hBB: transparent sprite colour.
REQ-008 clk  in  1  system clock; the only clock.
REQ-009 rst  in  1  synchronous, active-low reset.
REQ-010 pix_en  in  1  one-cycle pixel strobe; collision sampling occurs only when high.
REQ-011 pause  in  1  freezes movement and spawning.
REQ-012 game_start_on, game_over_on  in  1 each  game-state screens; either high blocks spawning.
REQ-013 p_on  in  1  current pixel lies on the player.
REQ-014 hit_w_enemy  in  1  current pixel lies on a live bullet.
REQ-015 x, y  in  10 each  current VGA pixel coordinates.
REQ-016 wave_speed  in  24  speed-tick reload value.
REQ-017 color_in  in  8  sprite ROM colour for (sprite_row, sprite_col), combinational.
REQ-018 sprite_row, sprite_col  out  4 each  ROM address for the lowest-index enemy whose 16x16 box covers (x,y); 0 when none.
REQ-019 is_active  out  N_ENEMIES  per-enemy alive mask.
REQ-020 e_w_on  out  1  current pixel is an opaque pixel of a live enemy.
REQ-021 rgb  out  8  equals color_in.
REQ-022 kill_pulse, escape_pulse  out  1 each  one-cycle event strobes.
REQ-023 kill_idx  out  3  index of the enemy killed by the latest kill_pulse.

Function
REQ-024 speed_clk SHALL count 0..wave_speed and wrap to 0; speed_tick = (speed_clk == 0); wave_speed = 0 yields a tick every cycle.
REQ-025 On a speed_tick with pause low, each active enemy SHALL advance y by 1.
REQ-026 An active enemy whose y reaches BOUND_DOWN-16 SHALL clear is_active on that tick and raise escape_pulse for one cycle.
REQ-027 With ZIGZAG=1, each active enemy SHALL also move x by ±1 per tick: direction starts +1 and reverses on the tick that x reaches BOUND_LEFT or BOUND_RIGHT-16 (x is clamped to the bound on that tick).
REQ-028 The spawn counter SHALL increment on each unpaused speed_tick while spawning is allowed; on reaching SPAWN_GAP it SHALL reset to 0 and activate the lowest-index inactive enemy at (X0+i*X_STEP, BOUND_UP), with direction +1.
REQ-029 The spawn counter SHALL hold when all enemies are active; no spawn occurs in that case.
REQ-030 The 16x16 box of enemy i SHALL cover x_i <= x < x_i+16 and y_i <= y < y_i+16.
REQ-031 e_w_on = box hit by the selected (lowest-index) enemy AND color_in != KEY_COLOR AND that enemy is active.
REQ-032 On pix_en with e_w_on and (p_on or hit_w_enemy), the selected enemy SHALL deactivate on the next clock; kill_pulse and kill_idx SHALL be registered in the same cycle.
REQ-033 Kill and escape of the same enemy in the same cycle SHALL report kill only.
REQ-034 A kill and a spawn in the same cycle SHALL both take effect; the spawn selects only among enemies that were inactive before that cycle.
REQ-035 game_over_on high SHALL deactivate all enemies on the next clock without raising any pulse.
REQ-036 pause SHALL freeze speed_clk, spawn counter, positions and directions; collisions remain active.
REQ-037 Position arithmetic SHALL be 10-bit unsigned; X0+i*X_STEP SHALL be evaluated at elaboration, and values >= BOUND_RIGHT-16 SHALL be an elaboration error.

Reset
REQ-038 With rst low at a clk edge: is_active = 0, all y = BOUND_UP, all x = spawn x, all directions +1, speed_clk = 0, spawn counter = 0, kill_pulse = escape_pulse = 0, kill_idx = 0.
REQ-039 Reset asserted mid-fall SHALL take priority over every other event in that cycle.

Verification
REQ-040 Reset release, wave_speed=0, SPAWN_GAP=2, game screens low -> is_active=4'b0001 after 2 ticks; 4'b1111 after 8 ticks.
REQ-041 Enemy 0 active at y=100, pix_en with pixel (170,105) opaque and hit_w_enemy=1 -> next cycle is_active[0]=0, kill_pulse=1, kill_idx=0.
REQ-042 Single enemy falling with wave_speed=0 -> escape_pulse exactly at the tick on which y reaches 495; enemy inactive afterwards.
REQ-043 ZIGZAG=1, enemy x=767 moving +1 -> on the next tick x=768, direction becomes -1, following tick x=767.
REQ-044 pause held 100 cycles mid-fall -> y, x and the spawn counter remain unchanged; a bullet hit during the pause still kills the enemy.
REQ-045 game_over_on pulsed with 3 enemies active -> is_active=0 next cycle, no kill_pulse or escape_pulse.
